// File: rtl/mul_share_pkg.sv
// Shared types and widths for the time-multiplexed 16x16 signed multiplier controller.
package mul_share_pkg;
  localparam int OP_W   = 16;
  localparam int PROD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/mul_tc_16_16.sv
// Combinational 16x16 two's-complement multiplier with full 32-bit product.
module mul_tc_16_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] product
);
  assign product = 32'($signed(a)) * 32'($signed(b));
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping mod N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int IW = $clog2(N);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
    return IW'((int'(base) + k) % N);
  endfunction

  // Scan from farthest to nearest so the requester closest to ptr is written last and wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (en && req[wrap_idx(ptr, k)]) begin
        gnt                  = '0;
        gnt[wrap_idx(ptr, k)] = 1'b1;
        gnt_idx              = wrap_idx(ptr, k);
      end
    end
  end
endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one registered-in/registered-out signed multiplier among N_REQ requesters
// with round-robin grant and a single tagged response channel.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*16-1:0]   req_a,
  input  logic [N_REQ*16-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [PROD_W-1:0]     rsp_product,
  output logic                  busy
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // a request is granted only when the response slot is empty or being retired that cycle.
  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, id_q, gnt_idx;
  logic [N_REQ-1:0]   gnt;
  logic [OP_W-1:0]    op_a, op_b, sel_a, sel_b;
  logic [PROD_W-1:0]  product;
  logic               grant_en, accept;

  assign grant_en  = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign accept    = |gnt;
  assign req_ready = gnt;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (grant_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  mul_tc_16_16 u_mul (
    .a       (op_a),
    .b       (op_b),
    .product (product)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_a = req_a[i*OP_W +: OP_W];
        sel_b = req_b[i*OP_W +: OP_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = accept ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      id_q        <= '0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_a  <= sel_a;
        op_b  <= sel_b;
        id_q  <= gnt_idx;
        ptr_q <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      end
      if (state_q == CALC) begin
        rsp_product <= product;
        rsp_id      <= id_q;
      end
    end
  end
endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl: expected responses queued at issue, checked by a monitor.
module tb_mul_share_ctrl;
  import mul_share_pkg::*;

  localparam int N  = 4;
  localparam int IW = $clog2(N);
  localparam int W  = IW + PROD_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*16-1:0]  req_a, req_b;
  logic             rsp_valid, rsp_ready;
  logic [IW-1:0]    rsp_id;
  logic [31:0]      rsp_product;
  logic             busy;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;

  mul_share_ctrl #(.N_REQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ex(input int id, input logic [31:0] p);
    return {IW'(id), p};
  endfunction

  // Monitor: every retired response must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got id=%0d product=0x%08h, want none", rsp_id, rsp_product);
      end else begin
        exp_w = exp_q.pop_front();
        check("rsp", {rsp_id, rsp_product}, exp_w);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  task automatic issue(input logic [N-1:0] mask, output logic [N-1:0] first);
    int cyc;
    logic [N-1:0] g;
    bit got;
    cyc = 0;
    got = 1'b0;
    first = '0;
    req_valid = mask;
    while (req_valid != '0 && cyc < 100) begin
      @(negedge clk);
      g = req_ready & req_valid;
      if (!got && g != '0) begin
        first = g;
        got = 1'b1;
      end
      tick();
      req_valid = req_valid & ~g;
      cyc++;
    end
    if (req_valid != '0) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: pending 0x%0h, want 0", req_valid);
      req_valid = '0;
    end
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (busy && cyc < 100);
    if (busy) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: busy=1, want 0");
    end
    tick();
  endtask

  logic [N-1:0] first;
  logic [15:0] ca [4];
  logic [15:0] cb [4];
  logic [31:0] cp [4];
  int last_acc;

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    repeat (2) tick();

    // Reset state
    @(negedge clk);
    check("rst_rsp_valid", W'(rsp_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_req_ready", W'(req_ready), W'(0));
    check("rst_rsp", {rsp_id, rsp_product}, W'(0));
    tick();
    rst = 1'b0;
    tick();

    // Single request with latency checks
    set_op(0, 16'hFFFD, 16'h0005);
    exp_q.push_back(ex(0, 32'hFFFFFFF1));
    req_valid = 4'b0001;
    @(negedge clk);
    check("single_req_ready", W'(req_ready), W'(4'b0001));
    tick();
    req_valid = '0;
    @(negedge clk);
    check("single_calc_valid", W'(rsp_valid), W'(0));
    check("single_calc_busy", W'(busy), W'(1));
    tick();
    @(negedge clk);
    check("single_resp_valid", W'(rsp_valid), W'(1));
    tick();
    @(negedge clk);
    check("single_after_busy", W'(busy), W'(0));
    tick();

    // Corner products on requester 2
    ca = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
    cb = '{16'h8000, 16'h8000, 16'hFFFF, 16'h1234};
    cp = '{32'h40000000, 32'hC0008000, 32'h00000001, 32'h00000000};
    for (int i = 0; i < 4; i++) begin
      set_op(2, ca[i], cb[i]);
      exp_q.push_back(ex(2, cp[i]));
      issue(4'b0100, first);
      check("corner_grant", W'(first), W'(4'b0100));
      wait_idle();
    end

    // Round-robin with all requesters held valid; restart pointer from 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, 16'(i + 1), 16'h0010);
    exp_q.push_back(ex(0, 32'h10));
    exp_q.push_back(ex(1, 32'h20));
    exp_q.push_back(ex(2, 32'h30));
    exp_q.push_back(ex(3, 32'h40));
    exp_q.push_back(ex(0, 32'h10));
    req_valid = 4'b1111;
    last_acc = 0;
    for (int k = 0; k < 5; k++) begin
      int w;
      logic [N-1:0] oh;
      w = 0;
      do begin
        @(negedge clk);
        w++;
        if (req_ready == '0) tick();
      end while (req_ready == '0 && w < 20);
      oh = N'(1) << (k % 4);
      check("rr_grant", W'(req_ready), W'(oh));
      if (k > 0) check("rr_spacing", W'(cyc_cnt - last_acc), W'(2));
      last_acc = cyc_cnt;
      tick();
    end
    req_valid = '0;
    wait_idle();

    // Backpressure: req1 then req3 (pointer is at 1)
    rsp_ready = 1'b0;
    set_op(1, 16'h0002, 16'h0003);
    set_op(3, 16'h0004, 16'h0005);
    exp_q.push_back(ex(1, 32'd6));
    exp_q.push_back(ex(3, 32'd20));
    req_valid = 4'b1010;
    @(negedge clk);
    check("bp_first_grant", W'(req_ready), W'(4'b0010));
    tick();
    req_valid = 4'b1000;
    @(negedge clk);
    check("bp_calc_ready", W'(req_ready), W'(0));
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", W'(rsp_valid), W'(1));
      check("bp_hold", {rsp_id, rsp_product}, ex(1, 32'd6));
      check("bp_ready", W'(req_ready), W'(0));
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_grant", W'(req_ready), W'(4'b1000));
    tick();
    req_valid = '0;
    wait_idle();

    // Reset while in CALC: in-flight result must vanish, pointer back to 0
    set_op(1, 16'h0007, 16'h0007);
    req_valid = 4'b0010;
    @(negedge clk);
    check("rst_mid_grant", W'(req_ready), W'(4'b0010));
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", W'(rsp_valid), W'(0));
    check("rst_mid_busy", W'(busy), W'(0));
    tick();
    set_op(0, 16'h0100, 16'h0100);
    set_op(1, 16'hFFFE, 16'h0003);
    exp_q.push_back(ex(0, 32'h00010000));
    exp_q.push_back(ex(1, 32'hFFFFFFFA));
    issue(4'b0011, first);
    check("rst_mid_first", W'(first), W'(4'b0001));
    wait_idle();

    // Withdrawal: req2 pulses while response is stalled (pointer at 2)
    rsp_ready = 1'b0;
    set_op(0, 16'h0003, 16'h0003);
    exp_q.push_back(ex(0, 32'd9));
    issue(4'b0001, first);
    check("wd_grant", W'(first), W'(4'b0001));
    tick();
    set_op(2, 16'h0005, 16'h0005);
    req_valid = 4'b0100;
    @(negedge clk);
    check("wd_ready", W'(req_ready), W'(0));
    check("wd_valid", W'(rsp_valid), W'(1));
    tick();
    req_valid = '0;
    tick();
    rsp_ready = 1'b1;
    wait_idle();
    repeat (4) tick();

    check("queue_empty", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Round-robin scheduler that shares one combinational mul_tc_16_16 instance (16x16 signed, 32-bit product) among N_REQ requesters.
- Each requester has a valid/ready request channel. All requesters share one valid/ready response channel, tagged with the requester ID.
- Owns the operand and result registers around the multiplier, so the multiply path is register-to-register.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- ID_W, $clog2(N_REQ), width of the response tag; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  N_REQ  request pending, one bit per requester.
- req_ready  output  N_REQ  one-hot grant/accept; at most one bit high.
- req_a  input  N_REQ*16  operand a, requester i at bits [i*16+15:i*16], two's complement.
- req_b  input  N_REQ*16  operand b, same packing.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_product  output  32  signed product a*b.
- busy  output  1  high when state is not IDLE.

Behaviour:
- States: IDLE, CALC, RESP. Encoding comes from the package.

Reset (rst=1 at a clock edge):
- state=IDLE and round-robin pointer ptr=0.
- Operand regs, rsp_id and rsp_product are cleared to 0.
- rsp_valid=0, busy=0, req_ready=0.
- Reset mid-operation discards any in-flight or held result; no response is emitted for it.

Grant (combinational):
- Grant is enabled when state==IDLE, or when state==RESP && rsp_ready.
- g = first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping mod N_REQ.
- req_ready = one-hot(g) if grant is enabled and any req_valid is set; otherwise 0.
- req_ready never depends on req_a/req_b. It depends on req_valid, state and rsp_ready only.

On an accept edge (grant enabled and a request present):
- Latch req_a[g] and req_b[g] into the operand regs, and g into id_q.
- ptr <= (g+1) mod N_REQ.
- state <= CALC.
- ptr changes only on an accept.

CALC, one cycle:
- rsp_product <= mul_tc_16_16(op_a, op_b); rsp_id <= id_q.
- state <= RESP.

RESP:
- rsp_valid=1. rsp_product and rsp_id stay stable until the handshake completes.
- rsp_ready=1 and a request present: result retired, new request accepted in the same cycle, state <= CALC.
- rsp_ready=1 and no request: state <= IDLE.
- rsp_ready=0: stay in RESP; req_ready=0 for all requesters (backpressure).

Timing:
- Latency: request accepted at edge T gives rsp_valid=1 in the cycle after edge T+1, i.e. 2 cycles.
- Peak throughput: 1 result per 2 cycles.

Other rules:
- Requesters must hold req_a/req_b stable while req_valid=1 and not accepted. Dropping req_valid before accept is legal and is simply not granted.
- Simultaneous requests: ties are resolved only by ptr order. Starvation-free: a requester holding valid is granted within N_REQ accepts.
- Arithmetic: full 32-bit signed product; no rounding or saturation. 0x8000*0x8000 = 0x40000000.

Decomposition:
- Package mul_share_pkg: state enum (IDLE=2'd0, CALC=2'd1, RESP=2'd2), OP_W=16, PROD_W=32.
- Sub-module rr_arbiter (params N; inputs req, ptr, en; output one-hot gnt and binary gnt_idx). It is purely combinational, and the pointer register lives in mul_share_ctrl.
- mul_tc_16_16 is instantiated unmodified between the operand regs and rsp_product.

Test Plan:
- Single request: req0 with a=0xFFFD (-3), b=0x0005, rsp_ready=1 → req_ready=0001 in the accept cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_product=0xFFFFFFF1; then busy=0.
- Corner products, each sent in turn on req2:
  - 0x8000*0x8000 → 0x40000000.
  - 0x7FFF*0x8000 → 0xC0008000.
  - 0xFFFF*0xFFFF → 0x00000001.
  - 0x0000*0x1234 → 0x00000000.
- Round-robin: all four req_valid held high with distinct operands (a=i+1, b=0x0010), rsp_ready=1 → rsp_id sequence 0,1,2,3,0; products 0x10, 0x20, 0x30, 0x40; one result every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles while req1 and req3 are valid → rsp_valid stays 1 with stable rsp_id/rsp_product and req_ready=0000. When rsp_ready rises, the same cycle shows the next grant (req_ready=0010 or 1000 per ptr).
- Reset mid-operation: assert rst while in CALC → next cycle rsp_valid=0, busy=0, ptr=0; with req0 and req1 valid afterwards, req0 is granted first and no stale response appears.
- Request withdrawal: req2 valid for one cycle while in RESP with rsp_ready=0, then dropped → req2 is never granted and no response has rsp_id=2.
